// File: rtl/core_id_issue_q_if.sv
// Upstream/downstream handshake bundle of the ID issue queue.
// The queue binds to the slave modport; the environment driving it uses master.
interface core_id_issue_q_if #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32
);
   // upstream (IF -> queue)
   logic              valid_in;
   logic              ready_in;
   logic [PC_W-1:0]   i_pc;
   logic [INST_W-1:0] i_inst;
   logic              i_branch_predict;
   // downstream (queue -> ID)
   logic              valid_out;
   logic              ready_out;
   logic [PC_W-1:0]   o_pc;
   logic [INST_W-1:0] o_inst;
   logic              o_branch_predict;

   modport master (
      output valid_in, i_pc, i_inst, i_branch_predict, ready_out,
      input  ready_in, valid_out, o_pc, o_inst, o_branch_predict
   );

   modport slave (
      input  valid_in, i_pc, i_inst, i_branch_predict, ready_out,
      output ready_in, valid_out, o_pc, o_inst, o_branch_predict
   );
endinterface

// File: rtl/core_id_issue_q.sv
// DEPTH-entry in-order issue queue between IF and the ID decoder.
// The head entry is held in a register loaded from the next read address,
// so the storage array is only ever read through a flop. Issue is held
// while the head has a RAW hazard against any producer port.
module core_id_issue_q #(
   parameter int DEPTH   = 4,
   parameter int PC_W    = 32,
   parameter int INST_W  = 32,
   parameter int NUM_HAZ = 2,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   core_id_issue_q_if.slave         q_if,
   input  logic                     i_head_rs1_ren,
   input  logic                     i_head_rs2_ren,
   input  logic [5*NUM_HAZ-1:0]     i_haz_rd_idx,
   input  logic [NUM_HAZ-1:0]       i_haz_rd_wen,
   input  logic                     i_pipe_flush_req,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [CNT_W-1:0]         o_stall_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   // entry layout: {pc, inst, branch_predict}
   localparam int ENT_W = PC_W + INST_W + 1;

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic [ENT_W-1:0] in_entry;
   logic [INST_W-1:0] head_inst;
   logic [4:0] head_rs1, head_rs2;
   logic [NUM_HAZ-1:0] haz_hit;
   logic empty, full, raw_conflict, push, pop;
   logic [OCC_W-1:0] cnt_after_pop;

   assign in_entry  = {q_if.i_pc, q_if.i_inst, q_if.i_branch_predict};
   assign head_inst = head_q[INST_W:1];
   assign head_rs1  = head_inst[19:15];
   assign head_rs2  = head_inst[24:20];

   // Per-producer RAW check against the head's source registers; x0 never hazards.
   for (genvar gi = 0; gi < NUM_HAZ; gi++) begin : g_haz
      logic [4:0] rd_idx;
      assign rd_idx      = i_haz_rd_idx[5*gi +: 5];
      assign haz_hit[gi] = i_haz_rd_wen[gi] & (rd_idx != 5'd0) &
                           ((i_head_rs1_ren & (head_rs1 == rd_idx)) |
                            (i_head_rs2_ren & (head_rs2 == rd_idx)));
   end

   assign raw_conflict = |haz_hit;
   assign empty        = (count_q == '0);
   assign full         = (count_q == OCC_W'(DEPTH));
   assign push         = q_if.valid_in & ~full & ~i_pipe_flush_req;
   assign pop          = q_if.valid_out & q_if.ready_out;

   assign q_if.ready_in         = ~full;
   assign q_if.valid_out        = ~empty & ~raw_conflict & ~i_pipe_flush_req;
   assign q_if.o_pc             = head_q[ENT_W-1 -: PC_W];
   assign q_if.o_inst           = head_inst;
   assign q_if.o_branch_predict = head_q[0];
   assign o_count               = count_q;
   assign o_stall_cnt           = stall_q;

   // Next-state for pointers, occupancy, head register and stall counter.
   always_comb begin
      cnt_after_pop = count_q - OCC_W'(pop);
      rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d      = wr_ptr_q + PTR_W'(push);
      count_d       = cnt_after_pop + OCC_W'(push);
      // An entry pushed into a queue that is empty after this cycle's pop
      // becomes the head directly; its array slot is not yet written.
      if (push && (cnt_after_pop == '0)) begin
         head_d = in_entry;
      end else if (cnt_after_pop != '0) begin
         head_d = mem_q[rd_ptr_d];
      end else begin
         head_d = '0;
      end
      stall_d = stall_q;
      if (~empty & raw_conflict & ~i_pipe_flush_req & (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
      if (i_pipe_flush_req) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         head_d   = '0;
      end
   end

   // Entry storage: written at the write pointer, no reset needed.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= in_entry;
      end
   end

   // Control state with synchronous reset; reset dominates flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         stall_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         stall_q  <= stall_d;
      end
   end

endmodule

// File: tb/tb_core_id_issue_q.sv
// Self-checking bench for core_id_issue_q: a queue-based scoreboard models
// the entries in flight; every cycle the head, handshake, occupancy and
// stall counters of a default instance and a CNT_W=2 instance are compared.
module tb_core_id_issue_q;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        bp;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   logic valid_in, ready_out, bp_in, flush;
   logic [31:0] pc_in, inst_in;
   logic rs1_ren, rs2_ren;
   logic [9:0] haz_idx;
   logic [1:0] haz_wen;
   logic [2:0] count0, count1;
   logic [15:0] stall0;
   logic [1:0]  stall1;

   int vectors = 0;
   int miscompares = 0;
   ent_t sb[$];
   int m_stall0 = 0;
   int m_stall1 = 0;

   always #5 clk = ~clk;

   core_id_issue_q_if #(.PC_W(32), .INST_W(32)) if0 ();
   core_id_issue_q_if #(.PC_W(32), .INST_W(32)) if1 ();

   assign if0.valid_in = valid_in;
   assign if0.i_pc = pc_in;
   assign if0.i_inst = inst_in;
   assign if0.i_branch_predict = bp_in;
   assign if0.ready_out = ready_out;
   assign if1.valid_in = valid_in;
   assign if1.i_pc = pc_in;
   assign if1.i_inst = inst_in;
   assign if1.i_branch_predict = bp_in;
   assign if1.ready_out = ready_out;

   core_id_issue_q #(.DEPTH(4), .PC_W(32), .INST_W(32), .NUM_HAZ(2), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .q_if(if0),
      .i_head_rs1_ren(rs1_ren), .i_head_rs2_ren(rs2_ren),
      .i_haz_rd_idx(haz_idx), .i_haz_rd_wen(haz_wen),
      .i_pipe_flush_req(flush), .o_count(count0), .o_stall_cnt(stall0)
   );

   core_id_issue_q #(.DEPTH(4), .PC_W(32), .INST_W(32), .NUM_HAZ(2), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .q_if(if1),
      .i_head_rs1_ren(rs1_ren), .i_head_rs2_ren(rs2_ren),
      .i_haz_rd_idx(haz_idx), .i_haz_rd_wen(haz_wen),
      .i_pipe_flush_req(flush), .o_count(count1), .o_stall_cnt(stall1)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic model_haz(input logic [31:0] inst);
      logic hit = 1'b0;
      for (int k = 0; k < 2; k++) begin
         logic [4:0] idx = haz_idx[5*k +: 5];
         if (haz_wen[k] && idx != 5'd0 &&
             ((rs1_ren && inst[19:15] == idx) || (rs2_ren && inst[24:20] == idx)))
            hit = 1'b1;
      end
      return hit;
   endfunction

   // One clock: compare at negedge against the model, advance the model, step to posedge+1.
   task automatic tick();
      ent_t h;
      logic haz, exp_vout, do_pop, do_push;
      @(negedge clk);
      h = '{pc: 32'h0, inst: 32'h0, bp: 1'b0};
      haz = 1'b0;
      if (sb.size() != 0) begin
         h = sb[0];
         haz = model_haz(h.inst);
      end
      exp_vout = (sb.size() != 0) && !haz && !flush;
      check_eq("valid_out", 64'(if0.valid_out), 64'(exp_vout));
      check_eq("ready_in", 64'(if0.ready_in), 64'(sb.size() < DEPTH));
      check_eq("o_pc", 64'(if0.o_pc), 64'(h.pc));
      check_eq("o_inst", 64'(if0.o_inst), 64'(h.inst));
      check_eq("o_bp", 64'(if0.o_branch_predict), 64'(h.bp));
      check_eq("o_count", 64'(count0), 64'(sb.size()));
      check_eq("stall_cnt", 64'(stall0), 64'(m_stall0));
      check_eq("stall_cnt_w2", 64'(stall1), 64'(m_stall1));
      check_eq("valid_out_w2", 64'(if1.valid_out), 64'(exp_vout));
      do_pop  = exp_vout && ready_out;
      do_push = valid_in && (sb.size() < DEPTH) && !flush;
      if (rst) begin
         sb.delete();
         m_stall0 = 0;
         m_stall1 = 0;
         $display("reset");
      end else begin
         if (sb.size() != 0 && haz && !flush) begin
            if (m_stall0 < 65535) m_stall0++;
            if (m_stall1 < 3) m_stall1++;
            $display("stall pc=%h stall_cnt=%0d", h.pc, m_stall0);
         end
         if (flush) begin
            sb.delete();
            $display("flush");
         end else begin
            if (do_pop) begin
               $display("pop  pc=%h inst=%h bp=%0d", h.pc, h.inst, h.bp);
               void'(sb.pop_front());
            end
            if (do_push) begin
               sb.push_back('{pc: pc_in, inst: inst_in, bp: bp_in});
               $display("push pc=%h inst=%h bp=%0d", pc_in, inst_in, bp_in);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input logic bp);
      valid_in = 1'b1;
      pc_in = pc;
      inst_in = inst;
      bp_in = bp;
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; ready_out = 1'b0; bp_in = 1'b0; flush = 1'b0;
      pc_in = '0; inst_in = '0; rs1_ren = 1'b0; rs2_ren = 1'b0;
      haz_idx = '0; haz_wen = '0;
      repeat (2) @(posedge clk);
      #1;
      tick();                       // reset state
      rst = 1'b0;

      // fill with backpressure, then over-offer while full, then drain in order
      for (int i = 0; i < 4; i++) begin
         offer(32'h100 + 32'(4*i), 32'h00000013 | (32'(i + 1) << 7), 1'(i));
         tick();
      end
      offer(32'h1F0, 32'h00000013, 1'b1);
      tick();                       // full: push refused
      valid_in = 1'b0;
      ready_out = 1'b1;
      repeat (5) tick();

      // RAW hazard on producer 1 (x2), then released
      rs1_ren = 1'b1; rs2_ren = 1'b1;
      haz_idx = {5'd2, 5'd0}; haz_wen = 2'b10;
      offer(32'h200, 32'h00208033, 1'b0);
      tick();
      valid_in = 1'b0;
      repeat (6) tick();
      haz_wen = 2'b00;
      tick();

      // both ports hit (x1 and x2): still one stall per cycle
      haz_idx = {5'd2, 5'd1}; haz_wen = 2'b11;
      offer(32'h204, 32'h00208033, 1'b1);
      tick();
      valid_in = 1'b0;
      repeat (2) tick();
      haz_wen = 2'b00;
      tick();

      // x0 producer never hazards
      haz_idx = {5'd0, 5'd0}; haz_wen = 2'b11;
      offer(32'h208, 32'h00000033, 1'b0);
      tick();
      valid_in = 1'b0;
      repeat (2) tick();
      haz_wen = 2'b00;

      // flush with three entries queued and an entry offered
      ready_out = 1'b0;
      for (int i = 0; i < 3; i++) begin
         offer(32'h300 + 32'(4*i), 32'h00000013, 1'b0);
         tick();
      end
      offer(32'h30C, 32'h00000013, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      valid_in = 1'b0;
      repeat (2) tick();

      // continuous streaming across pointer wrap, with a reset mid-stream
      ready_out = 1'b1;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         offer(32'h400 + 32'(4*i), $urandom, 1'($urandom_range(0, 1)));
         rst = (i == 7);
         tick();
      end
      rst = 1'b0;
      valid_in = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/core_id_issue_q.md
Name: core_id_issue_q

Overview:
- Parametrised successor to the single-entry ID pipeline register: a DEPTH-entry in-order queue of fetched {pc, inst, branch_predict} between IF and the ID decoder.
- The head entry's instruction goes to the external decoder, which returns the head's rs1/rs2 read enables.
- Issue is held while the head has a RAW hazard against any of NUM_HAZ producer ports, e.g. EX, MEM and load-use.
- Adds a pipeline flush and a saturating stall-cycle counter.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- PC_W, 32, pc width.
- INST_W, 32, instruction width; rs1 = inst[19:15], rs2 = inst[24:20].
- NUM_HAZ, 2, number of producer (hazard) ports.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream entry valid.
- ready_in  out  1  queue can accept an entry.
- i_pc  in  PC_W  fetched pc.
- i_inst  in  INST_W  fetched instruction.
- i_branch_predict  in  1  predicted-taken flag.
- valid_out  out  1  head entry issuable.
- ready_out  in  1  downstream accepts the head.
- o_pc  out  PC_W  head pc.
- o_inst  out  INST_W  head instruction.
- o_branch_predict  out  1  head prediction flag.
- i_head_rs1_ren  in  1  decoder: head reads rs1.
- i_head_rs2_ren  in  1  decoder: head reads rs2.
- i_haz_rd_idx  in  5*NUM_HAZ  producer k's rd index, in bits [5k+4:5k].
- i_haz_rd_wen  in  NUM_HAZ  producer k writes rd.
- i_pipe_flush_req  in  1  discard all entries.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst=1 at clock edge): read pointer, write pointer, o_count and o_stall_cnt all go to 0. Storage contents are don't-care.
  - Reset values: valid_out=0, ready_in=1, o_pc/o_inst/o_branch_predict = 0 (registered output muxes are masked when the queue is empty).
- Reset mid-operation discards all entries; no push/pop takes effect in that cycle.
- Derived signals:
  - empty = (o_count == 0).
  - full = (o_count == DEPTH).
  - ready_in = ~full. Registered-state only; there is no combinational path from ready_out. A full queue with a simultaneous pop still refuses the push.
  - push = valid_in & ready_in & ~i_pipe_flush_req.
  - hit_k = i_haz_rd_wen[k] & (idx_k != 0) & ((i_head_rs1_ren & rs1 == idx_k) | (i_head_rs2_ren & rs2 == idx_k)), where rs1/rs2 are taken from the head entry.
  - raw_conflict = OR of hit_k over all k.
  - valid_out = ~empty & ~raw_conflict & ~i_pipe_flush_req.
  - pop = valid_out & ready_out.
- Head outputs reflect the entry at the read pointer whenever the queue is non-empty, regardless of valid_out.
- Latency: an entry pushed in cycle N is visible at the head no earlier than cycle N+1. There is no bypass.
- Pointers wrap modulo DEPTH.
- o_count: +1 on push only, -1 on pop only, unchanged when both or neither.
- Flush (i_pipe_flush_req=1):
  - Pointers and o_count go to 0 at the next edge.
  - valid_out is 0 during the flush cycle.
  - An input offered in the flush cycle is dropped.
  - o_stall_cnt is not cleared.
- Flush and reset together: reset wins; the result is identical.
- Stall counter increments when ~empty & raw_conflict & ~i_pipe_flush_req, and saturates at 2^CNT_W-1.
- An x0 destination (idx_k == 0) never causes a hazard.
- Hazard on both rs1 and rs2, or from several ports at once, counts as one stall cycle.
- Downstream backpressure (ready_out=0) with no hazard does not count as a stall.

Test Plan:
- Reset, then push 4 entries (pc 0x100, 0x104, 0x108, 0x10C) with ready_out=0 -> o_count=4, ready_in=0, o_pc=0x100. Then raise ready_out -> pops in order over 4 cycles and o_count returns to 0.
- Head inst 0x00208033 (add x0,x1,x2) with rs1_ren=rs2_ren=1, and producer 1 has idx=2, wen=1 -> valid_out=0 and o_stall_cnt rises by 1 per cycle. Drop wen -> valid_out=1 in the same cycle.
- Producer idx=0, wen=1, head rs1=0 -> no stall, valid_out=1.
- Queue holding 3 entries, assert i_pipe_flush_req with valid_in=1 -> valid_out=0 that cycle. Next cycle o_count=0 (the offered entry was dropped) and o_stall_cnt is unchanged.
- CNT_W=2 instance with a 6-cycle hazard -> o_stall_cnt holds at 3.
- Wrap-around: push/pop continuously for 3*DEPTH entries with an incrementing pc -> exact in-order pc sequence and no loss; a rst pulse mid-stream -> o_count=0 and valid_out=0 on the next cycle.
